// File: rtl/mips_dp_pkg.sv
// Shared definitions for the pipelined MIPS datapath: default word width,
// select-width helper and the skid-buffer occupancy states.
package mips_dp_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    // A binary select always needs at least one bit, even for a 1- or 2-way mux.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dp_skid_buffer.sv
// Two-entry valid/ready skid buffer with synchronous flush. in_ready is taken
// straight from registers, so there is no combinational path from out_ready.
module dp_skid_buffer
    import mips_dp_pkg::*;
#(
    parameter int W = DATA_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    buf_state_t   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         rdy_q;
    logic         accept, xfer;

    // rdy_q keeps in_ready low while reset is held and for the edge it is released on.
    assign in_ready  = rdy_q && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            main_q  <= main_d;
        end
    end

    // Skid contents are meaningless unless state_q is FULL, so they need no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N:1 datapath multiplexer feeding a registered, back-pressurable skid buffer;
// sel_err is carried through the buffer alongside the selected word.
module mux_nx1_pipe
    import mips_dp_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int N_IN     = 3,
    parameter int SEL_W    = clog2_min1(N_IN),
    parameter bit ZERO_BAD = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);

    logic [WIDTH-1:0] chan [N_IN];
    logic [WIDTH-1:0] sel_word;
    logic             sel_hit;
    logic [WIDTH:0]   buf_out;

    for (genvar k = 0; k < N_IN; k++) begin : g_chan
        assign chan[k] = in_data[k*WIDTH +: WIDTH];
    end

    // A select that matches no channel falls back to zero or channel 0 and flags the word.
    always_comb begin
        sel_hit  = 1'b0;
        sel_word = ZERO_BAD ? '0 : chan[0];
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_hit  = 1'b1;
                sel_word = chan[k];
            end
        end
    end

    dp_skid_buffer #(
        .W (WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   ({~sel_hit, sel_word}),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (buf_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign sel_err  = buf_out[WIDTH];
    assign out_data = buf_out[WIDTH-1:0];

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: three configurations checked against a queue model
// every cycle, plus directed vectors with literal expectations.
module tb_mux_nx1_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Configurations a (ZERO_BAD=1) and b (ZERO_BAD=0) share one stimulus set.
    logic [95:0] in_data_ab;
    logic [1:0]  sel_ab;
    logic        in_valid_ab, flush_ab, out_ready_ab;
    logic        in_ready_a, out_valid_a, sel_err_a;
    logic        in_ready_b, out_valid_b, sel_err_b;
    logic [31:0] out_data_a, out_data_b;

    logic [39:0] in_data_c;
    logic [2:0]  sel_c;
    logic        in_valid_c, flush_c, out_ready_c;
    logic        in_ready_c, out_valid_c, sel_err_c;
    logic [7:0]  out_data_c;

    int checks = 0;
    int passes = 0;

    mux_nx1_pipe #(.WIDTH(32), .N_IN(3), .ZERO_BAD(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_ab), .sel(sel_ab),
        .in_valid(in_valid_ab), .in_ready(in_ready_a), .flush(flush_ab),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_ab),
        .sel_err(sel_err_a));

    mux_nx1_pipe #(.WIDTH(32), .N_IN(3), .ZERO_BAD(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_ab), .sel(sel_ab),
        .in_valid(in_valid_ab), .in_ready(in_ready_b), .flush(flush_ab),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_ab),
        .sel_err(sel_err_b));

    mux_nx1_pipe #(.WIDTH(8), .N_IN(5), .ZERO_BAD(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_c), .sel(sel_c),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .flush(flush_c),
        .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .sel_err(sel_err_c));

    task automatic check(input string nm, input int k, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s (dut %0d) at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
    endtask

    // Expected {sel_err, data} for a word taken now.
    function automatic logic [32:0] exp_ab(input logic [95:0] d, input logic [1:0] s,
                                           input bit zb);
        int i;
        i = int'(s);
        if (i < 3) return {1'b0, d[i*32 +: 32]};
        return {1'b1, zb ? 32'd0 : d[31:0]};
    endfunction

    function automatic logic [32:0] exp_c(input logic [39:0] d, input logic [2:0] s);
        int i;
        i = int'(s);
        if (i < 5) return {1'b0, 24'd0, d[i*8 +: 8]};
        return {1'b1, 32'd0};
    endfunction

    logic        iv [3];
    logic        ordy [3];
    logic        fl [3];
    logic [32:0] w [3];
    logic        ov [3];
    logic        ir [3];
    logic [32:0] od [3];

    always_comb begin
        iv[0] = in_valid_ab;  iv[1] = in_valid_ab;  iv[2] = in_valid_c;
        ordy[0] = out_ready_ab; ordy[1] = out_ready_ab; ordy[2] = out_ready_c;
        fl[0] = flush_ab;     fl[1] = flush_ab;     fl[2] = flush_c;
        w[0] = exp_ab(in_data_ab, sel_ab, 1'b1);
        w[1] = exp_ab(in_data_ab, sel_ab, 1'b0);
        w[2] = exp_c(in_data_c, sel_c);
        ov[0] = out_valid_a;  ov[1] = out_valid_b;  ov[2] = out_valid_c;
        ir[0] = in_ready_a;   ir[1] = in_ready_b;   ir[2] = in_ready_c;
        od[0] = {sel_err_a, out_data_a};
        od[1] = {sel_err_b, out_data_b};
        od[2] = {sel_err_c, 24'd0, out_data_c};
    end

    // Model: the buffer is a FIFO of at most two words; ready comes one edge after reset.
    logic [32:0] mq [3][$];
    bit          rdy_m [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mq[k].delete();
                rdy_m[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit acc, xfr;
                acc = iv[k] && rdy_m[k] && (mq[k].size() < 2);
                xfr = ordy[k] && (mq[k].size() > 0);
                if (fl[k]) begin
                    mq[k].delete();
                end else begin
                    if (xfr) void'(mq[k].pop_front());
                    if (acc) mq[k].push_back(w[k]);
                end
                rdy_m[k] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 3; k++) begin
                check("out_valid", k, 64'(ov[k]), 64'(mq[k].size() > 0));
                check("in_ready", k, 64'(ir[k]), 64'(rdy_m[k] && (mq[k].size() < 2)));
                if (mq[k].size() > 0) check("out_word", k, 64'(od[k]), 64'(mq[k][0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] r;
        rst_n = 1'b0;
        in_data_ab = {32'hC, 32'hB, 32'hA};
        sel_ab = 2'd0; in_valid_ab = 1'b1; flush_ab = 1'b0; out_ready_ab = 1'b1;
        in_data_c = '0; sel_c = '0; in_valid_c = 1'b0; flush_c = 1'b0; out_ready_c = 1'b1;

        // Reset held with a word offered
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 0, 64'(out_valid_a), 64'd0);
        check("rst_out_data", 0, 64'(out_data_a), 64'd0);
        check("rst_sel_err", 0, 64'(sel_err_a), 64'd0);
        rst_n = 1'b1;
        in_valid_ab = 1'b0;
        step();
        check("ready_after_rst", 0, 64'(in_ready_a), 64'd1);

        // Select sweep, back to back
        in_valid_ab = 1'b1; sel_ab = 2'd0;
        step(); check("sweep0", 0, 64'({sel_err_a, out_data_a}), 64'h0_0000000A);
        sel_ab = 2'd1;
        step(); check("sweep1", 0, 64'({sel_err_a, out_data_a}), 64'h0_0000000B);
        sel_ab = 2'd2;
        step(); check("sweep2", 0, 64'({sel_err_a, out_data_a}), 64'h0_0000000C);

        // Out-of-range select
        sel_ab = 2'd3;
        step();
        check("bad_sel_zero", 0, 64'({sel_err_a, out_data_a}), 64'h1_00000000);
        check("bad_sel_ch0", 1, 64'({sel_err_b, out_data_b}), 64'h1_0000000A);
        in_valid_ab = 1'b0; sel_ab = 2'd1;
        step(); check("drained", 0, 64'(out_valid_a), 64'd0);

        // Backpressure: 1,2,3 with the output stalled
        out_ready_ab = 1'b0; sel_ab = 2'd0; in_valid_ab = 1'b1;
        in_data_ab[31:0] = 32'd1;
        step(); check("bp_ready1", 0, 64'(in_ready_a), 64'd1);
        in_data_ab[31:0] = 32'd2;
        step(); check("bp_full_ready", 0, 64'(in_ready_a), 64'd0);
        in_data_ab[31:0] = 32'd3;
        step(); check("bp_hold", 0, 64'(out_data_a), 64'd1);
        out_ready_ab = 1'b1;
        step(); check("bp_out2", 0, 64'(out_data_a), 64'd2);
        step(); check("bp_out3", 0, 64'(out_data_a), 64'd3);
        in_valid_ab = 1'b0;
        step(); check("bp_empty", 0, 64'(out_valid_a), 64'd0);

        // Flush while FULL with a word offered
        out_ready_ab = 1'b0; in_valid_ab = 1'b1;
        in_data_ab[31:0] = 32'd4; step();
        in_data_ab[31:0] = 32'd5; step();
        in_data_ab[31:0] = 32'd6; flush_ab = 1'b1;
        step();
        check("flush_valid", 0, 64'(out_valid_a), 64'd0);
        check("flush_ready", 0, 64'(in_ready_a), 64'd1);
        check("flush_keep_data", 0, 64'(out_data_a), 64'd4);

        // Flush beats a simultaneous accept while ONE
        flush_ab = 1'b0; in_data_ab[31:0] = 32'd7; step();
        in_data_ab[31:0] = 32'd8; flush_ab = 1'b1;
        step(); check("flush_one_data", 0, 64'(out_data_a), 64'd7);
        flush_ab = 1'b0; in_valid_ab = 1'b0;
        step(); check("flush_dropped", 0, 64'(out_valid_a), 64'd0);

        // Asynchronous reset with a word buffered
        in_valid_ab = 1'b1; in_data_ab[31:0] = 32'd9;
        step(); in_valid_ab = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 0, 64'(out_valid_a), 64'd0);
        check("async_rst_data", 0, 64'(out_data_a), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready_ab = 1'b1;
        step(); check("ready_after_rst2", 0, 64'(in_ready_a), 64'd1);

        // Random traffic on the 5-input, 8-bit configuration
        for (int n = 0; n < 10000; n++) begin
            r = {$urandom(), $urandom()};
            in_data_c   = r[39:0];
            sel_c       = 3'($urandom_range(0, 7));
            in_valid_c  = 1'($urandom_range(0, 1));
            out_ready_c = ($urandom_range(0, 3) != 0);
            flush_c     = ($urandom_range(0, 63) == 0);
            step();
        end
        in_valid_c = 1'b0; flush_c = 1'b0; out_ready_c = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
